// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the uart_regs two-port arbiter.
// Holds the FSM state encoding, data/address widths, legal read-latency
// bounds, the 16550 register map and a clamp helper for the read-latency
// counter load value.
package uart_arb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  localparam int RD_LAT_MIN = 0;
  localparam int RD_LAT_MAX = 3;

  // 16550 register map
  localparam logic [ADDR_W-1:0] UART_RBR = 3'd0;
  localparam logic [ADDR_W-1:0] UART_THR = 3'd0;
  localparam logic [ADDR_W-1:0] UART_IER = 3'd1;
  localparam logic [ADDR_W-1:0] UART_IIR = 3'd2;
  localparam logic [ADDR_W-1:0] UART_FCR = 3'd2;
  localparam logic [ADDR_W-1:0] UART_LCR = 3'd3;
  localparam logic [ADDR_W-1:0] UART_MCR = 3'd4;
  localparam logic [ADDR_W-1:0] UART_LSR = 3'd5;
  localparam logic [ADDR_W-1:0] UART_MSR = 3'd6;
  localparam logic [ADDR_W-1:0] UART_SCR = 3'd7;

  // Saturates a read latency into the 2-bit wait counter range.
  function automatic logic [1:0] rd_lat_load(input int lat);
    if (lat < RD_LAT_MIN) return 2'd0;
    if (lat > RD_LAT_MAX) return 2'd3;
    return 2'(lat);
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// uart_arb_rr_pick: combinational two-way round-robin selector.
// Ports:
//   req0, req1  - pending requests
//   last_owner  - index of the most recently granted port
//   locked      - when high only last_owner may be granted
//   grant       - a port is granted this cycle
//   grant_idx   - index of the granted port (last_owner when no grant)
module uart_arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic locked,
  output logic grant,
  output logic grant_idx
);

  always_comb begin
    grant     = 1'b0;
    grant_idx = last_owner;
    if (locked) begin
      grant     = last_owner ? req1 : req0;
      grant_idx = last_owner;
    end else if (req0 && req1) begin
      // tie goes to whoever did not have the bus last
      grant     = 1'b1;
      grant_idx = ~last_owner;
    end else if (req0) begin
      grant     = 1'b1;
      grant_idx = 1'b0;
    end else if (req1) begin
      grant     = 1'b1;
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/uart_reg_arbiter.sv
// uart_reg_arbiter: serialises single-register accesses from two requesters
// onto the uart_regs bus with round-robin fairness. Each access produces one
// we/re strobe, read data is captured RD_LAT cycles after the strobe and the
// winning port receives a one-cycle ack.
// Parameters:
//   RD_LAT - cycles from uart_re_o to valid uart_rdata_i (0..3)
// Ports:
//   CLK, RESET                  - clock, synchronous active-high reset
//   req*_i, addr*_i, we*_i,
//   wdata*_i, lock*_i           - requester side inputs (port 0 / port 1)
//   ack*_o, rdata*_o            - requester side completion and read data
//   uart_addr_o, uart_wdata_o,
//   uart_we_o, uart_re_o,
//   uart_rdata_i                - bus to uart_regs
//   busy_o                      - access in progress (state not IDLE)
//   owner_o                     - current or last granted port
// Build option: define UART_ARB_LOCK_EN to let the owner hold the grant
// across accesses via lock*_i; otherwise lock*_i is ignored.
module uart_reg_arbiter
  import uart_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] uart_addr_o,
  output logic [DATA_W-1:0] uart_wdata_o,
  output logic              uart_we_o,
  output logic              uart_re_o,
  input  logic [DATA_W-1:0] uart_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  arb_state_e state;
  logic [1:0] wait_cnt;
  logic       grant;
  logic       grant_idx;
  logic       sel_we;
  logic       locked;

`ifndef UART_ARB_LOCK_EN
  logic lock_unused;
  assign locked      = 1'b0;
  assign lock_unused = lock0_i | lock1_i;
`endif

  uart_arb_rr_pick u_pick (
    .req0       (req0_i),
    .req1       (req1_i),
    .last_owner (owner_o),
    .locked     (locked),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_we = grant_idx ? we1_i : we0_i;
  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      wait_cnt     <= 2'd0;
      owner_o      <= 1'b1;
      uart_addr_o  <= '0;
      uart_wdata_o <= '0;
      uart_we_o    <= 1'b0;
      uart_re_o    <= 1'b0;
      ack0_o       <= 1'b0;
      ack1_o       <= 1'b0;
      rdata0_o     <= '0;
      rdata1_o     <= '0;
`ifdef UART_ARB_LOCK_EN
      locked       <= 1'b0;
`endif
    end else begin
      unique case (state)
        // IDLE: arbitrate and latch the winner's access onto the bus
        ST_IDLE: begin
          if (grant) begin
            owner_o      <= grant_idx;
            uart_addr_o  <= grant_idx ? addr1_i : addr0_i;
            uart_wdata_o <= grant_idx ? wdata1_i : wdata0_i;
            uart_we_o    <= sel_we;
            uart_re_o    <= ~sel_we;
            state        <= ST_STROBE;
          end
        end
        // STROBE: single-cycle we/re; zero-latency reads capture here
        ST_STROBE: begin
          uart_we_o <= 1'b0;
          uart_re_o <= 1'b0;
          if (uart_we_o || RD_LAT == 0) begin
            if (!uart_we_o) begin
              if (owner_o) rdata1_o <= uart_rdata_i;
              else         rdata0_o <= uart_rdata_i;
            end
            ack0_o <= ~owner_o;
            ack1_o <= owner_o;
            state  <= ST_ACK;
          end else begin
            wait_cnt <= rd_lat_load(RD_LAT);
            state    <= ST_WAIT;
          end
        end
        // WAIT: read data is valid in the cycle the counter reaches 1
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            if (owner_o) rdata1_o <= uart_rdata_i;
            else         rdata0_o <= uart_rdata_i;
            ack0_o <= ~owner_o;
            ack1_o <= owner_o;
            state  <= ST_ACK;
          end
        end
        // ACK: ack pulse ends, optional grant hold is decided
        ST_ACK: begin
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
`ifdef UART_ARB_LOCK_EN
          locked <= owner_o ? lock1_i : lock0_i;
`endif
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
